// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// Provides the clear/ready state encoding, write-port indices and the address-width helper.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int WP_ALU  = 0;
    localparam int WP_LOAD = 1;

    function automatic int rf_aw(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus between decode/writeback (master) and the register file (slave).
// Read addresses, both write ports, the clear request and the ready flag travel together.
interface regfile_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    import regfile_pkg::*;

    localparam int AW = rf_aw(NREGS);

    // wr_en[i] is the valid for write port i. A write takes effect at the edge
    // only while ready is high; there is no other backpressure, and a write
    // presented while ready is low is dropped rather than held.
    logic                  clr;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*XLEN-1:0]   rd_data;
    logic [1:0]            wr_en;
    logic [AW-1:0]         wr_addr0;
    logic [AW-1:0]         wr_addr1;
    logic [XLEN-1:0]       wr_data0;
    logic [XLEN-1:0]       wr_data1;
    logic                  ready;

    modport master (
        output clr, rd_addr, wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  rd_data, ready
    );

    modport slave (
        input  clr, rd_addr, wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output rd_data, ready
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps zeroes into every entry after reset or a clr request,
// then holds READY until the next clr.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = rf_aw(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    output rf_state_e       state,
    output logic            ready,
    output logic            clr_we,
    output logic [AW-1:0]   clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                // The sweep only writes on edges where reset is released, so a
                // reset edge never disturbs the array contents.
                clr_we = rst_n;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = RF_READY;
                    cnt_d   = '0;
                end
            end
            RF_READY: begin
                if (clr) begin
                    state_d = RF_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign state    = state_q;
    assign ready    = (state_q == RF_READY);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write ports
// (load wins on conflict), optional same-cycle bypass and a hardwired zero entry.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_if.slave    bus,
    output rf_state_e   state
);

    localparam int AW = rf_aw(NREGS);

    logic [XLEN-1:0] mem [NREGS];

    logic            ready;
    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            wr_ok;
    logic [1:0]      we;
    logic [AW-1:0]   wa [2];
    logic [XLEN-1:0] wd [2];
    logic [AW-1:0]   rd_idx  [NRD];
    logic [XLEN-1:0] rd_word [NRD];

    regfile_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (bus.clr),
        .state    (state),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign bus.ready = ready;
    assign wr_ok     = ready && rst_n;

    always_comb begin
        wa[WP_ALU]  = bus.wr_addr0;
        wa[WP_LOAD] = bus.wr_addr1;
        wd[WP_ALU]  = bus.wr_data0;
        wd[WP_LOAD] = bus.wr_data1;
        for (int i = 0; i < 2; i++) begin
            we[i] = wr_ok && bus.wr_en[i] && !((ZERO_REG != 0) && (wa[i] == '0));
        end
    end

    // The load port is assigned last so it wins when both ports hit one entry.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            if (we[WP_ALU]) begin
                mem[wa[WP_ALU]] <= wd[WP_ALU];
            end
            if (we[WP_LOAD]) begin
                mem[wa[WP_LOAD]] <= wd[WP_LOAD];
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_idx[k]  = bus.rd_addr[k*AW +: AW];
            rd_word[k] = mem[rd_idx[k]];
            if (BYPASS != 0) begin
                if (we[WP_ALU] && (wa[WP_ALU] == rd_idx[k])) begin
                    rd_word[k] = wd[WP_ALU];
                end
                if (we[WP_LOAD] && (wa[WP_LOAD] == rd_idx[k])) begin
                    rd_word[k] = wd[WP_LOAD];
                end
            end
            if ((ZERO_REG != 0) && (rd_idx[k] == '0)) begin
                rd_word[k] = '0;
            end
            if (!ready) begin
                rd_word[k] = '0;
            end
            bus.rd_data[k*XLEN +: XLEN] = rd_word[k];
        end
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file, the successor to the single-cycle core's 2R/1W register file. It adds configurable width, depth and read-port count, and a second write port for the load/writeback split. It also adds optional same-cycle write-to-read bypass and a hardware clear sequencer that zeroes every entry after reset or on request. It sits between decode (read addresses) and writeback (write ports) in the datapath.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of entries (power of two, ≥4)
- NRD, 2, number of read ports (1–4)
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns stored data
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes
- AW, derived, $clog2(NREGS)

- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- clr  in  1  one-cycle pulse; restarts the clear sweep
- rd_addr  in  NRD*AW  read addresses; port k at [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port k at [k*XLEN +: XLEN]
- wr_en  in  2  write enables, port 0 = ALU writeback, port 1 = load writeback
- wr_addr0, wr_addr1  in  AW each  write addresses
- wr_data0, wr_data1  in  XLEN each  write data
- ready  out  1  high when the clear sweep is done and writes are accepted

## Operation
- States: CLEAR and READY.
- rst_n low at a clock edge: state is CLEAR and sweep counter cnt is 0. Array contents are not otherwise touched by reset.
- In CLEAR, with rst_n high: each edge writes 0 to entry cnt, then cnt increments. The edge that writes entry NREGS-1 moves the state to READY.
- clr high in READY: next state is CLEAR with cnt = 0. clr in CLEAR is ignored; the sweep does not restart.
- Writes:
  - Accepted only in READY.
  - wr_en[i] writes wr_data_i to wr_addr_i at the edge.
  - wr_en is ignored in CLEAR.
  - If ZERO_REG = 1, writes to address 0 are discarded.
- Both ports writing the same address in one cycle: port 1 (load) wins.
- Reads are combinational from the array.
  - Address 0 with ZERO_REG = 1 returns 0.
  - In CLEAR, every port returns 0.
- Bypass (BYPASS = 1, READY only): if wr_en[i] is set and wr_addr_i equals rd_addr k, rd_data k returns wr_data_i. Port 1 has priority over port 0. The ZERO_REG rule overrides bypass.
- Reset asserted mid-sweep: the sweep restarts from cnt = 0.

## Timing
- Reset values: ready = 0, state = CLEAR, cnt = 0. rd_data = 0 while in CLEAR.
- ready rises NREGS edges after the first edge sampling rst_n high.
- clr handling:
  - clr sampled at edge E: ready is low from E until it rises NREGS edges later.
  - A write presented in the same cycle as clr is accepted, then overwritten by the sweep.
- Write latency is one edge. With BYPASS = 0, the value is readable in the cycle after the write. With BYPASS = 1, it is readable in the same cycle.
- No stalls; there is no backpressure beyond ready.

## Structure
- Package regfile_pkg holds:
  - the state enum {RF_CLEAR, RF_READY}
  - the localparam/function for AW
  - the write-port index constants WP_ALU = 0 and WP_LOAD = 1
- Sub-module regfile_clear_seq holds the state register, the cnt counter, ready, and the clear-write strobe/address. The array, write arbitration and read/bypass muxes stay in regfile_mp.

## Test plan
- Reset and sweep: hold rst_n low 3 cycles, then release; ready rises exactly 32 edges later; all 32 entries read 0.
- Write/read with BYPASS = 0: write 0xDEADBEEF to r5 on port 0; rd_addr0 = 5 shows the old value that cycle and 0xDEADBEEF the next cycle. Bypass build: 0xDEADBEEF appears the same cycle.
- Dual-write conflict: port 0 writes 0x1111 and port 1 writes 0x2222, both to r7, same cycle; r7 then reads 0x2222. Bypass same cycle also returns 0x2222.
- Zero register: write 0xFFFFFFFF to r0 on both ports; all read ports addressing r0 return 0, with and without bypass.
- clr mid-run:
  - Fill r1–r31 with their own index, then pulse clr; ready drops the next cycle.
  - Writes during the sweep are dropped, and reads return 0.
  - After 32 edges, all entries are 0.
  - Assert rst_n low at cnt = 10; the sweep restarts and ready rises 32 edges after release.
